dac_sigma_delta: RTL and testbench

//  Digital-to-analog end of the converter path: takes an 8-bit code plus a start strobe and emits a

---
 rtl/dac_pkg.sv | 8 +
 rtl/dac_sd_core.sv | 36 +++
 rtl/dac_sigma_delta.sv | 120 ++++++++++++
 tb/tb_dac_sigma_delta.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/dac_pkg.sv
// Shared types and defaults for the sigma-delta DAC.
package dac_pkg;

  typedef enum logic {DAC_IDLE, DAC_RUN} dac_state_t;

  localparam int unsigned DAC_DEF_WIDTH = 8;

endpackage

// File: rtl/dac_sd_core.sv
// First-order sigma-delta modulator: accumulator plus registered carry bit.
module dac_sd_core
  import dac_pkg::*;
#(
  parameter int unsigned WIDTH = DAC_DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] code,
  output logic             bit_out
);

  logic [WIDTH-1:0] acc_q;
  logic [WIDTH:0]   sum;

  assign sum = {1'b0, acc_q} + {1'b0, code};

  // clr and en may coincide on a back-to-back reload: the last bit still
  // comes out while the accumulator restarts from zero for the next run.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      bit_out <= 1'b0;
    end else begin
      bit_out <= en & sum[WIDTH];
      if (clr) begin
        acc_q <= '0;
      end else if (en) begin
        acc_q <= sum[WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/dac_sigma_delta.sv
// Sigma-delta DAC top: run FSM, window counter and one-deep pending slot.
// Define DAC_ONES_COUNT_EN to add the ones_count output.
module dac_sigma_delta
  import dac_pkg::*;
#(
  parameter int unsigned WIDTH   = DAC_DEF_WIDTH,
  parameter int unsigned WINDOWS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] digital_input,
  output logic             analog_output,
  output logic             busy,
  output logic             done,
`ifdef DAC_ONES_COUNT_EN
  output logic [WIDTH+$clog2(WINDOWS+1)-1:0] ones_count,
`endif
  output logic [WIDTH-1:0] code_active
);

  localparam int unsigned RunLen = WINDOWS << WIDTH;
  localparam int unsigned CntW   = $clog2(RunLen);

  dac_state_t       state_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] code_q;
  logic [WIDTH-1:0] pend_q;
  logic             pend_v_q;
  logic             busy_q;
  logic             done_q;
  logic             last;
  logic             reload;
  logic             core_en;
  logic             core_clr;

  assign last     = (cnt_q == CntW'(RunLen - 1));
  assign reload   = last & (start | pend_v_q);
  assign core_en  = (state_q == DAC_RUN);
  assign core_clr = (state_q == DAC_IDLE) | (core_en & reload);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= DAC_IDLE;
      cnt_q    <= '0;
      code_q   <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        DAC_IDLE: begin
          if (start) begin
            code_q  <= digital_input;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= DAC_RUN;
          end
        end
        DAC_RUN: begin
          cnt_q <= cnt_q + 1'b1;
          if (last) begin
            done_q   <= 1'b1;
            pend_v_q <= 1'b0;
            if (reload) begin
              // A start on this edge is newer than anything in the slot.
              code_q <= start ? digital_input : pend_q;
              cnt_q  <= '0;
            end else begin
              busy_q  <= 1'b0;
              state_q <= DAC_IDLE;
            end
          end else if (start) begin
            pend_q   <= digital_input;
            pend_v_q <= 1'b1;
          end
        end
        default: state_q <= DAC_IDLE;
      endcase
    end
  end

  dac_sd_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk    (clk),
    .rst    (rst),
    .clr    (core_clr),
    .en     (core_en),
    .code   (code_q),
    .bit_out(analog_output)
  );

  assign busy        = busy_q;
  assign done        = done_q;
  assign code_active = code_q;

`ifdef DAC_ONES_COUNT_EN
  localparam int unsigned OnesW = WIDTH + $clog2(WINDOWS + 1);

  logic [OnesW-1:0] ones_base_q;

  // Base holds ones already seen; the bit on the wire is added on top so the
  // done cycle already includes the final bit. Restart when bit 0 is produced.
  always_ff @(posedge clk) begin
    if (rst) begin
      ones_base_q <= '0;
    end else if ((state_q == DAC_IDLE && start) || (state_q == DAC_RUN && cnt_q == '0)) begin
      ones_base_q <= '0;
    end else begin
      ones_base_q <= ones_base_q + OnesW'(analog_output);
    end
  end

  assign ones_count = ones_base_q + OnesW'(analog_output);
`endif

endmodule

// File: tb/tb_dac_sigma_delta.sv
// Scoreboard bench for dac_sigma_delta: per-run ones, bit pattern, done timing.
module tb_dac_sigma_delta;

  localparam int W   = 8;
  localparam int WIN = 1;
  localparam int N   = WIN << W;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] digital_input = '0;
  logic         analog_output;
  logic         busy;
  logic         done;
  logic [W-1:0] code_active;
`ifdef DAC_ONES_COUNT_EN
  logic [W+$clog2(WIN+1)-1:0] ones_count;
`endif

  dac_sigma_delta #(
    .WIDTH  (W),
    .WINDOWS(WIN)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .digital_input(digital_input),
    .analog_output(analog_output),
    .busy         (busy),
    .done         (done),
`ifdef DAC_ONES_COUNT_EN
    .ones_count   (ones_count),
`endif
    .code_active  (code_active)
  );

  always #5 clk = ~clk;

  typedef struct {
    int code;
    int ones;
    bit busy_after;
  } exp_t;

  exp_t sb[$];
  int   done_cyc[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Monitor: a sample is a stream bit iff the DUT was busy at the previous sample.
  int bits = 0, ones = 0, bad = 0, prev_busy = 0;
  always @(posedge clk) begin
    #1;
    cyc++;
    if (rst) begin
      bits = 0; ones = 0; bad = 0; prev_busy = 0;
    end else begin
      if (prev_busy != 0) begin
        if (sb.size() == 0) begin
          check_eq("bit_without_expect", sb.size(), 1);
        end else begin
          int c, eb;
          c  = sb[0].code;
          eb = (((bits + 1) * c) >> W) - ((bits * c) >> W);
          if (int'(analog_output) != eb) bad++;
          if (bits == 0) check_eq("code_active", int'(code_active), c);
          bits++;
          ones += int'(analog_output);
        end
      end
      if (done) begin
        if (sb.size() == 0) begin
          check_eq("done_without_expect", sb.size(), 1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check_eq("run_ones", ones, e.ones);
          check_eq("run_bits", bits, N);
          check_eq("bit_pattern_errs", bad, 0);
          check_eq("busy_at_done", int'(busy), int'(e.busy_after));
`ifdef DAC_ONES_COUNT_EN
          check_eq("ones_count", int'(ones_count), e.ones);
`endif
        end
        done_cyc.push_back(cyc);
        bits = 0; ones = 0; bad = 0;
      end
      prev_busy = int'(busy);
    end
  end

  task automatic push_exp(input int code, input bit busy_after);
    exp_t e;
    e.code = code;
    e.ones = WIN * code;
    e.busy_after = busy_after;
    sb.push_back(e);
  endtask

  // Start is sampled by exactly one rising edge.
  task automatic pulse(input int code);
    start = 1'b1;
    digital_input = W'(code);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int t;
    t = 0;
    while (sb.size() != 0 && t < 4 * N + 100) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      check_eq({tag, "_timeout"}, sb.size(), 0);
      sb.delete();
    end
    @(negedge clk);
    check_eq({tag, "_idle_busy"}, int'(busy), 0);
    check_eq({tag, "_idle_done"}, int'(done), 0);
    check_eq({tag, "_idle_out"}, int'(analog_output), 0);
  endtask

  initial begin
    // 1: reset with start held high
    rst = 1'b1;
    start = 1'b1;
    digital_input = 8'hAB;
    repeat (3) @(negedge clk);
    check_eq("rst_out", int'(analog_output), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_done", int'(done), 0);
    check_eq("rst_code", int'(code_active), 0);
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check_eq("post_rst_busy", int'(busy), 0);

    // 2: single run
    push_exp(8'h12, 1'b0);
    pulse(8'h12);
    check_eq("busy_after_start", int'(busy), 1);
    check_eq("out_after_start", int'(analog_output), 0);
    wait_drain("run12");

    // 3: extremes and mid-scale alternation
    push_exp(8'h00, 1'b0); pulse(8'h00); wait_drain("run00");
    push_exp(8'hFF, 1'b0); pulse(8'hFF); wait_drain("runff");
    push_exp(8'h80, 1'b0); pulse(8'h80); wait_drain("run80");

    // 4: latest pending wins, back-to-back without a gap
    done_cyc.delete();
    push_exp(8'hA5, 1'b1);
    push_exp(8'h10, 1'b0);
    pulse(8'hA5);
    repeat (99) @(negedge clk);
    pulse(8'h40);
    repeat (49) @(negedge clk);
    pulse(8'h10);
    wait_drain("pend");
    if (done_cyc.size() == 2) check_eq("done_spacing", done_cyc[1] - done_cyc[0], N);
    else check_eq("done_count", done_cyc.size(), 2);

    // 5: start on the final edge reloads immediately
    done_cyc.delete();
    push_exp(8'h33, 1'b1);
    push_exp(8'h33, 1'b0);
    pulse(8'h33);
    repeat (N - 1) @(negedge clk);
    pulse(8'h33);
    wait_drain("final_edge");
    if (done_cyc.size() == 2) check_eq("final_spacing", done_cyc[1] - done_cyc[0], N);
    else check_eq("final_done_count", done_cyc.size(), 2);

    // 6: reset mid-run drops the run and the pending code
    push_exp(8'h12, 1'b0);
    pulse(8'h12);
    repeat (19) @(negedge clk);
    pulse(8'h55);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    sb.delete();
    check_eq("mid_rst_out", int'(analog_output), 0);
    check_eq("mid_rst_busy", int'(busy), 0);
    check_eq("mid_rst_done", int'(done), 0);
    check_eq("mid_rst_code", int'(code_active), 0);
    rst = 1'b0;
    repeat (N + 20) @(negedge clk);
    check_eq("pending_lost_busy", int'(busy), 0);
    push_exp(8'h22, 1'b0);
    pulse(8'h22);
    wait_drain("after_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
